// File: rtl/hit_count_memory_pkg.sv
// Shared definitions for the hit-count memory (HCM).
//   NROWS_HCM / ROWINDEXBITS_HCM / NCOLS_HCM : default geometry of the counter RAM
//   SSIDBITS                                 : SSID width used by the surrounding pipeline
//   hcm_state_e                              : top-level controller states
package hit_count_memory_pkg;

  localparam int unsigned NROWS_HCM        = 65536;
  localparam int unsigned ROWINDEXBITS_HCM = 16;
  localparam int unsigned NCOLS_HCM        = 16;
  localparam int unsigned SSIDBITS         = 16;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } hcm_state_e;

endpackage

// File: rtl/hit_count_memory_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents (read-first).
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address, data appears on rdata after the next rising edge
//   rdata : registered read data
module hcm_ram #(
  parameter int unsigned DEPTH = 65536,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hit_count_memory.sv
// Hit-count memory: per-row saturating hit counters with read-modify-write
// update, a 2-cycle read port and a post-reset clear sweep.
//   clk             : rising-edge clock
//   reset           : asynchronous, active-low reset
//   writeRow        : update strobe (row restarts at 1 if SSIDIsNew, else +1)
//   inputRowToWrite : row to update
//   SSIDIsNew       : first occurrence of the SSID in the event
//   readRow         : read strobe
//   inputRowToRead  : row to read
//   writeReady      : write strobe accepted this cycle
//   readReady       : read strobe accepted this cycle
//   rowPassed       : index of the row on rowReadOutput
//   rowReadOutput   : row contents, 2 cycles after readRow
//   busy            : clear sweep in progress
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_SWEEP | writing zeros to every row, one per cycle; strobes dropped
// ST_RUN   | normal operation, both ports accept strobes
module hit_count_memory
  import hit_count_memory_pkg::*;
#(
  parameter int unsigned NROWS    = NROWS_HCM,
  parameter int unsigned ROW_BITS = ROWINDEXBITS_HCM,
  parameter int unsigned NCOLS    = NCOLS_HCM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                writeRow,
  input  logic [ROW_BITS-1:0] inputRowToWrite,
  input  logic                SSIDIsNew,
  input  logic                readRow,
  input  logic [ROW_BITS-1:0] inputRowToRead,
  output logic                writeReady,
  output logic                readReady,
  output logic [ROW_BITS-1:0] rowPassed,
  output logic [NCOLS-1:0]    rowReadOutput,
  output logic                busy
);

  localparam int unsigned         RAM_AW   = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NROWS - 1);
  localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);
  localparam logic [NCOLS-1:0]    CNT_ONE  = NCOLS'(1);
  localparam logic [NCOLS-1:0]    CNT_MAX  = {NCOLS{1'b1}};

  hcm_state_e          state_q;
  logic [ROW_BITS-1:0] sweep_row_q;

  // write pipeline: A = registered strobe, B = modify, C/D = recently committed
  logic                wa_vld_q, wb_vld_q, wc_vld_q, wd_vld_q;
  logic [ROW_BITS-1:0] wa_row_q, wb_row_q, wc_row_q, wd_row_q;
  logic                wa_new_q, wb_new_q;
  logic [NCOLS-1:0]    wc_val_q, wd_val_q;
  logic [NCOLS-1:0]    wb_old_d, wb_val_d;

  // read pipeline: A = registered strobe, B = RAM data available
  logic                ra_vld_q, rb_vld_q;
  logic [ROW_BITS-1:0] ra_row_q, rb_row_q;
  logic                ra_oor_q, rb_oor_q;
  logic [NCOLS-1:0]    rb_val_d;

  logic [ROW_BITS-1:0] row_passed_q;
  logic [NCOLS-1:0]    row_data_q;

  logic                wr_acc, rd_acc, rd_in_range;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_waddr;
  logic [NCOLS-1:0]    ram_wdata;
  logic [NCOLS-1:0]    ram_wr_rdata, ram_rd_rdata;

  assign busy       = (state_q == ST_SWEEP);
  assign writeReady = ~busy;
  assign readReady  = ~busy;

  assign wr_acc      = writeRow & ~busy & (32'(inputRowToWrite) < NROWS);
  assign rd_acc      = readRow & ~busy;
  assign rd_in_range = (32'(inputRowToRead) < NROWS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SWEEP;
      sweep_row_q <= '0;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          if (sweep_row_q == LAST_ROW) state_q <= ST_RUN;
          sweep_row_q <= sweep_row_q + ROW_ONE;
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_SWEEP;
      endcase
    end
  end

  // The RAM read for a modify captures before the previous modify's write
  // lands (read-first), so the newest committed write (C) must be forwarded;
  // D is forwarded as well so the read port and write port share one rule.
  always_comb begin
    wb_old_d = ram_wr_rdata;
    if (wd_vld_q && (wd_row_q == wb_row_q)) wb_old_d = wd_val_q;
    if (wc_vld_q && (wc_row_q == wb_row_q)) wb_old_d = wc_val_q;

    if (wb_new_q)                wb_val_d = CNT_ONE;
    else if (wb_old_d == CNT_MAX) wb_val_d = CNT_MAX;
    else                          wb_val_d = wb_old_d + CNT_ONE;

    // The write in B during this cycle was strobed alongside the read and
    // must stay invisible, so only C and D are forwarded.
    rb_val_d = ram_rd_rdata;
    if (wd_vld_q && (wd_row_q == rb_row_q)) rb_val_d = wd_val_q;
    if (wc_vld_q && (wc_row_q == rb_row_q)) rb_val_d = wc_val_q;
    if (rb_oor_q)                           rb_val_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wa_vld_q <= 1'b0;  wa_row_q <= '0;  wa_new_q <= 1'b0;
      wb_vld_q <= 1'b0;  wb_row_q <= '0;  wb_new_q <= 1'b0;
      wc_vld_q <= 1'b0;  wc_row_q <= '0;  wc_val_q <= '0;
      wd_vld_q <= 1'b0;  wd_row_q <= '0;  wd_val_q <= '0;
    end else begin
      wa_vld_q <= wr_acc;
      wa_row_q <= inputRowToWrite;
      wa_new_q <= SSIDIsNew;
      wb_vld_q <= wa_vld_q;
      wb_row_q <= wa_row_q;
      wb_new_q <= wa_new_q;
      wc_vld_q <= wb_vld_q;
      wc_row_q <= wb_row_q;
      wc_val_q <= wb_val_d;
      wd_vld_q <= wc_vld_q;
      wd_row_q <= wc_row_q;
      wd_val_q <= wc_val_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra_vld_q     <= 1'b0;  ra_row_q <= '0;  ra_oor_q <= 1'b0;
      rb_vld_q     <= 1'b0;  rb_row_q <= '0;  rb_oor_q <= 1'b0;
      row_passed_q <= '0;
      row_data_q   <= '0;
    end else begin
      ra_vld_q <= rd_acc;
      ra_row_q <= inputRowToRead;
      ra_oor_q <= ~rd_in_range;
      rb_vld_q <= ra_vld_q;
      rb_row_q <= ra_row_q;
      rb_oor_q <= ra_oor_q;
      if (rb_vld_q) begin
        row_passed_q <= rb_row_q;
        row_data_q   <= rb_val_d;
      end
    end
  end

  assign rowPassed     = row_passed_q;
  assign rowReadOutput = row_data_q;

  // The sweep and the modify stage never overlap: the pipeline is empty
  // whenever busy is set.
  assign ram_we    = busy | wb_vld_q;
  assign ram_waddr = busy ? sweep_row_q[RAM_AW-1:0] : wb_row_q[RAM_AW-1:0];
  assign ram_wdata = busy ? '0 : wb_val_d;

  // Two identical copies share the write port so the modify stage and the
  // read port each get their own read port.
  hcm_ram #(.DEPTH(NROWS), .AW(RAM_AW), .DW(NCOLS)) u_ram_wr (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (wa_row_q[RAM_AW-1:0]),
    .rdata (ram_wr_rdata)
  );

  hcm_ram #(.DEPTH(NROWS), .AW(RAM_AW), .DW(NCOLS)) u_ram_rd (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ra_row_q[RAM_AW-1:0]),
    .rdata (ram_rd_rdata)
  );

endmodule

// File: tb/tb_hit_count_memory.sv
module tb_hit_count_memory;

  localparam int NR   = 4096;
  localparam int RB   = 16;
  localparam int NC   = 8;
  localparam int CMAX = (1 << NC) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          writeRow;
  logic [RB-1:0] inputRowToWrite;
  logic          SSIDIsNew;
  logic          readRow;
  logic [RB-1:0] inputRowToRead;
  logic          writeReady;
  logic          readReady;
  logic [RB-1:0] rowPassed;
  logic [NC-1:0] rowReadOutput;
  logic          busy;

  always #5 clk = ~clk;

  hit_count_memory #(.NROWS(NR), .ROW_BITS(RB), .NCOLS(NC)) dut (
    .clk             (clk),
    .reset           (reset),
    .writeRow        (writeRow),
    .inputRowToWrite (inputRowToWrite),
    .SSIDIsNew       (SSIDIsNew),
    .readRow         (readRow),
    .inputRowToRead  (inputRowToRead),
    .writeReady      (writeReady),
    .readReady       (readReady),
    .rowPassed       (rowPassed),
    .rowReadOutput   (rowReadOutput),
    .busy            (busy)
  );

  typedef struct {
    int row;
    int val;
    int due;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          exp_ready = 1'b0;
  int unsigned model [NR];
  exp_t        sb[$];
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      check_eq("rd_row", 32'(rowPassed), mon_e.row);
      check_eq("rd_val", 32'(rowReadOutput), mon_e.val);
    end
  end

  // One cycle of stimulus; the scoreboard sees the read before the same-cycle write.
  task automatic drive(input bit wr, input int wrow, input bit wnew, input bit rd, input int rrow);
    exp_t e;
    writeRow        = wr;
    inputRowToWrite = RB'(wrow);
    SSIDIsNew       = wnew;
    readRow         = rd;
    inputRowToRead  = RB'(rrow);
    if (rd && exp_ready) begin
      e.row = rrow;
      e.val = (rrow < NR) ? int'(model[rrow]) : 0;
      e.due = cyc + 3;
      sb.push_back(e);
    end
    if (wr && exp_ready && wrow < NR) begin
      if (wnew)                    model[wrow] = 1;
      else if (model[wrow] != CMAX) model[wrow] = model[wrow] + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic wr(input int row, input bit is_new);
    drive(1'b1, row, is_new, 1'b0, 0);
  endtask

  task automatic rd(input int row);
    drive(1'b0, 0, 1'b0, 1'b1, row);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) idle(1);
    check_eq("sb_drain", 32'(sb.size()), 0);
  endtask

  // Assert reset now, hold 3 cycles, release and time the sweep. With noisy
  // set, the strobes left on the inputs stay asserted and more are driven
  // while busy; none of them may have any effect.
  task automatic reset_and_sweep(input bit noisy);
    int cnt;
    reset = 1'b0;
    sb.delete();
    foreach (model[i]) model[i] = 0;
    exp_ready = 1'b0;
    if (!noisy) begin
      writeRow = 1'b0; readRow = 1'b0; SSIDIsNew = 1'b0;
      inputRowToWrite = '0; inputRowToRead = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 1);
    check_eq("rst_wready", 32'(writeReady), 0);
    check_eq("rst_rready", 32'(readReady), 0);
    check_eq("rst_rowpassed", 32'(rowPassed), 0);
    check_eq("rst_rowdata", 32'(rowReadOutput), 0);
    reset = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < NR + 16) begin
      cnt++;
      if (noisy && cnt <= 24) begin
        writeRow = 1'b1; inputRowToWrite = RB'(20 + cnt % 12); SSIDIsNew = cnt[0];
        readRow  = 1'b1; inputRowToRead  = RB'(20 + cnt % 12);
      end else begin
        writeRow = 1'b0; readRow = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("busy_len", cnt, NR);
    check_eq("post_wready", 32'(writeReady), 1);
    check_eq("post_rready", 32'(readReady), 1);
    repeat (3) @(negedge clk);
    check_eq("post_rowpassed", 32'(rowPassed), 0);
    check_eq("post_rowdata", 32'(rowReadOutput), 0);
    exp_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b0;
    writeRow = 1'b0; readRow = 1'b0; SSIDIsNew = 1'b0;
    inputRowToWrite = '0; inputRowToRead = '0;
    @(negedge clk);
    reset_and_sweep(1'b0);

    // cleared memory at both ends of the array
    for (int r = 0; r < 50; r++) rd(r);
    for (int r = NR - 50; r < NR; r++) rd(r);
    drain();

    // interleaved updates near the top of the array
    wr(NR - 2, 1'b1); wr(NR - 3, 1'b1);
    wr(NR - 2, 1'b0); wr(NR - 2, 1'b0); wr(NR - 2, 1'b0);
    idle(3); rd(NR - 2); rd(NR - 3);
    drain();

    // back-to-back and alternate-cycle accumulation
    wr(1, 1'b1); repeat (4) wr(1, 1'b0);
    wr(2, 1'b1); idle(1); wr(2, 1'b0); idle(1); wr(2, 1'b0);
    idle(3); rd(1); rd(2);
    drain();

    // restart on a new SSID
    wr(4, 1'b1); wr(4, 1'b0); wr(4, 1'b0);
    idle(3); rd(4);
    wr(4, 1'b1); idle(3); rd(4);
    drain();

    // same-row read and write every cycle: read sees only earlier writes
    for (int i = 0; i < 8; i++) drive(1'b1, 9, (i == 0), 1'b1, 9);
    rd(9);
    drain();

    // saturation
    wr(7, 1'b1);
    repeat (CMAX - 1) wr(7, 1'b0);
    idle(3); rd(7);
    wr(7, 1'b0); wr(7, 1'b0);
    idle(3); rd(7);
    drain();

    // out-of-range indices
    wr(65534, 1'b0); wr(NR, 1'b1);
    idle(3); rd(65534); rd(NR);
    drain();

    // random mix on a small row set
    for (int i = 0; i < 300; i++)
      drive(1'(($urandom_range(1, 0))), int'($urandom_range(15, 0)),
            ($urandom_range(3, 0) == 0), 1'(($urandom_range(1, 0))),
            int'($urandom_range(15, 0)));
    for (int r = 0; r < 16; r++) rd(r);
    drain();

    // reset in the middle of a write burst with a read in flight
    wr(30, 1'b1); wr(30, 1'b0);
    drive(1'b1, 30, 1'b0, 1'b1, 30);
    #2;
    reset_and_sweep(1'b1);
    for (int r = 16; r < 36; r++) rd(r);
    rd(NR - 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_count_memory.md
Name: hit_count_memory

Overview:
- Hit-count memory (HCM) for the pattern-matching pipeline: a RAM of NROWS_HCM rows, each NCOLS_HCM bits wide, indexed by row number.
- Each write performs a read-modify-write on the addressed row:
  - first hit for an SSID in the event (SSIDIsNew=1): the row is restarted at 1;
  - repeat hit: the row is incremented.
- The read port returns a row together with its index for downstream consumers.
- After reset the block sweeps the memory clear, signalling busy for the duration.

Parameters:
- NROWS_HCM, 65536, number of rows.
- ROWINDEXBITS_HCM, 16, row index width; must satisfy 2^ROWINDEXBITS_HCM >= NROWS_HCM.
- NCOLS_HCM, 16, row data width (hit counter).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- writeRow, input, 1, write (read-modify-write) strobe.
- inputRowToWrite, input, ROWINDEXBITS_HCM, row to update.
- SSIDIsNew, input, 1, sampled with writeRow; 1 = first occurrence in the event.
- readRow, input, 1, read strobe.
- inputRowToRead, input, ROWINDEXBITS_HCM, row to read.
- writeReady, output, 1, write port accepts a strobe this cycle.
- readReady, output, 1, read port accepts a strobe this cycle.
- rowPassed, output, ROWINDEXBITS_HCM, index of the row presented on rowReadOutput.
- rowReadOutput, output, NCOLS_HCM, row contents.
- busy, output, 1, clear sweep in progress.

Behaviour:
- Memory: simple dual-port synchronous RAM (1-cycle read latency), inferable as BRAM.
- Reset asserted (low):
  - all pipeline registers are cleared;
  - rowPassed=0, rowReadOutput=0;
  - busy=1, writeReady=0, readReady=0.
- Clear sweep after reset release:
  - zeros are written to rows 0..NROWS_HCM-1, one row per cycle;
  - busy stays 1 for NROWS_HCM cycles, then drops to 0;
  - writeReady = readReady = ~busy.
- Strobes while not ready: silently dropped, with no state change.
- Reset mid-sweep or mid-operation: the sweep restarts from row 0; in-flight operations are discarded.
- Write pipeline:
  - cycle 0: strobe, index and SSIDIsNew are registered;
  - cycle 1: RAM read of the old value;
  - cycle 2: new value is written back.
  - New value = 1 if SSIDIsNew, else old+1, saturating at all-ones (no wrap).
  - One write accepted per cycle, fully pipelined.
- Read-after-write hazard:
  - the modify stage forwards from the writes in its two younger stages;
  - back-to-back or alternate-cycle writes to the same row therefore accumulate exactly.
  - Example: five consecutive non-new writes to row 1 with value 0 give 5.
- Read port:
  - readRow in cycle N presents rowReadOutput and rowPassed=inputRowToRead at the rising edge ending cycle N+2 (2-cycle latency);
  - one read accepted per cycle;
  - the outputs hold their last value when no read is in flight.
- Simultaneous read and write:
  - to different rows: both proceed independently.
  - to the same row: the read returns the value after all writes accepted strictly before the read's cycle. Writes committed in the same cycle are not visible; forwarding is applied to the read as well.
- Index arithmetic:
  - indices >= NROWS_HCM are ignored (write dropped, read returns 0 with rowPassed echoed).
  - All counters are unsigned.

Decomposition:
- Shared package/header: NROWS_HCM, ROWINDEXBITS_HCM, NCOLS_HCM, SSIDBITS.
- One sub-module, hcm_ram: parameterised simple dual-port RAM (write port, registered read port).
- Control, sweep, forwarding and saturation logic live in the top.

Test Plan:
- Reset low 3 cycles, then release:
  - busy=1 for exactly NROWS_HCM cycles, then 0;
  - reading rows 0..49 and 65486..65535 returns 0 with matching rowPassed, 2 cycles after each strobe.
- Write sequence (row,new), one per cycle:
  - (65534,1),(65533,1),(65534,0),(65534,0),(65534,0) gives row 65534=4 and row 65533=1.
- Sequence (1,1),(1,0),(1,0),(1,0),(1,0) back-to-back gives row 1=5, which checks forwarding.
- Row 4 written (4,1),(4,0),(4,0):
  - row 4 reads 3;
  - a subsequent (4,1) restarts it at 1.
- Preload row 7 to all-ones, then (7,0): row 7 stays all-ones (saturation).
- Assert reset mid-write-burst:
  - no partial write survives;
  - the sweep restarts and all rows read 0 afterwards;
  - strobes issued while busy=1 have no effect.
